// File: rtl/ad9361_port_emu_pkg.sv
// Shared definitions for the AD9361 port emulator: word indices, frame pattern,
// half-word slice positions, decoder states and sample-set packing helpers.
package ad9361_port_emu_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned SET_W  = 48;

  localparam logic [1:0] IDX_0 = 2'd0;
  localparam logic [1:0] IDX_1 = 2'd1;
  localparam logic [1:0] IDX_2 = 2'd2;
  localparam logic [1:0] IDX_3 = 2'd3;

  // Frame bit expected at each word index, LSB is index 0.
  localparam logic [3:0] FRAME_PATTERN = 4'b0011;

  localparam int unsigned HI_MSB = 11;
  localparam int unsigned HI_LSB = 6;
  localparam int unsigned LO_MSB = 5;
  localparam int unsigned LO_LSB = 0;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] q1;
    logic [WORD_W-1:0] i1;
    logic [WORD_W-1:0] q0;
    logic [WORD_W-1:0] i0;
  } sample_set_t;

  function automatic logic [WORD_W-1:0] set_word(input sample_set_t s, input logic [1:0] idx);
    logic [WORD_W-1:0] w;
    case (idx)
      IDX_0:   w = {s.q0[HI_MSB:HI_LSB], s.i0[HI_MSB:HI_LSB]};
      IDX_1:   w = {s.q0[LO_MSB:LO_LSB], s.i0[LO_MSB:LO_LSB]};
      IDX_2:   w = {s.q1[HI_MSB:HI_LSB], s.i1[HI_MSB:HI_LSB]};
      IDX_3:   w = {s.q1[LO_MSB:LO_LSB], s.i1[LO_MSB:LO_LSB]};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic sample_set_t set_put(input sample_set_t s, input logic [1:0] idx,
                                          input logic [WORD_W-1:0] w);
    sample_set_t r;
    r = s;
    case (idx)
      IDX_0: begin
        r.q0[HI_MSB:HI_LSB] = w[HI_MSB:HI_LSB];
        r.i0[HI_MSB:HI_LSB] = w[LO_MSB:LO_LSB];
      end
      IDX_1: begin
        r.q0[LO_MSB:LO_LSB] = w[HI_MSB:HI_LSB];
        r.i0[LO_MSB:LO_LSB] = w[LO_MSB:LO_LSB];
      end
      IDX_2: begin
        r.q1[HI_MSB:HI_LSB] = w[HI_MSB:HI_LSB];
        r.i1[HI_MSB:HI_LSB] = w[LO_MSB:LO_LSB];
      end
      IDX_3: begin
        r.q1[LO_MSB:LO_LSB] = w[HI_MSB:HI_LSB];
        r.i1[LO_MSB:LO_LSB] = w[LO_MSB:LO_LSB];
      end
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ad9361_sample_fifo.sv
// Sample-set FIFO with a first-word-fall-through head; DEPTH must be a power of two.
module ad9361_sample_fifo
  import ad9361_port_emu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [SET_W-1:0]            data_i,
  input  logic                        pop_i,
  output logic [SET_W-1:0]            head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [SET_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CNT_FULL);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ad9361_port_emu.sv
// AD9361-side 2R2T port emulator: frames buffered sample sets onto rx_frame/rx_data
// and decodes tx_frame/tx_data back into sample sets while tracking alignment.
module ad9361_port_emu
  import ad9361_port_emu_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [WORD_W-1:0] src_i0,
  input  logic [WORD_W-1:0] src_q0,
  input  logic [WORD_W-1:0] src_i1,
  input  logic [WORD_W-1:0] src_q1,
  output logic              rx_frame,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_underrun,
  input  logic              tx_frame,
  input  logic [WORD_W-1:0] tx_data,
  output logic              snk_valid,
  output logic [WORD_W-1:0] snk_i0,
  output logic [WORD_W-1:0] snk_q0,
  output logic [WORD_W-1:0] snk_i1,
  output logic [WORD_W-1:0] snk_q1,
  output logic              tx_locked,
  output logic              tx_err,
  output logic [15:0]       err_count
);

  localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LOCK_C   = 4'(LOCK_FRAMES);

  // RX framer
  logic [1:0]        step_q, step_d;
  sample_set_t       hold_q, hold_d;
  logic              rx_frame_q, rx_frame_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_urun_q, rx_urun_d;
  logic              src_ready_q, src_ready_d;
  sample_set_t       src_set, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_d;

  assign src_set   = {src_q1, src_i1, src_q0, src_i0};
  assign fifo_push = src_valid && src_ready_q && !fifo_full;
  assign fifo_pop  = (step_q == IDX_3) && !fifo_empty;

  ad9361_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .data_i (src_set),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    step_d    = step_q + 2'd1;
    hold_d    = hold_q;
    rx_urun_d = 1'b0;
    if (step_q == IDX_3) begin
      if (!fifo_empty) begin
        hold_d = fifo_head;
      end else begin
        hold_d    = '0;
        rx_urun_d = 1'b1;
      end
    end else begin
      hold_d = hold_q;
    end
    rx_frame_d = !step_d[1];
    rx_data_d  = set_word(hold_d, step_d);
    // Ready reflects the occupancy after this edge, so it never lags a pop.
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = fifo_count + CW'(1);
      2'b01:   count_d = fifo_count - CW'(1);
      default: count_d = fifo_count;
    endcase
    src_ready_d = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= IDX_3;
      hold_q      <= '0;
      rx_frame_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_urun_q   <= 1'b0;
      src_ready_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      hold_q      <= hold_d;
      rx_frame_q  <= rx_frame_d;
      rx_data_q   <= rx_data_d;
      rx_urun_q   <= rx_urun_d;
      src_ready_q <= src_ready_d;
    end
  end

  // TX decoder
  logic              f_q, f_p_q, rise;
  logic [WORD_W-1:0] w_q;
  tx_state_e         state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  sample_set_t       stage_q, stage_d, snk_q, snk_d;
  logic              snk_valid_q, snk_valid_d;
  logic [3:0]        good_q, good_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  assign rise = f_q && !f_p_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_d     = stage_q;
    snk_d       = snk_q;
    snk_valid_d = 1'b0;
    good_d      = good_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (rise) begin
          stage_d = set_put(stage_q, IDX_0, w_q);
          idx_d   = IDX_1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_RUN: begin
        if (f_q == FRAME_PATTERN[idx_q]) begin
          stage_d = set_put(stage_q, idx_q, w_q);
          idx_d   = idx_q + 2'd1;
          if (idx_q == IDX_3) begin
            snk_d       = stage_d;
            snk_valid_d = 1'b1;
            good_d      = (good_q == LOCK_C) ? good_q : good_q + 4'd1;
            locked_d    = locked_q || (good_d == LOCK_C);
          end else begin
            snk_valid_d = 1'b0;
          end
        end else begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
          locked_d  = 1'b0;
          good_d    = 4'd0;
          // A rising frame bit on the bad word is itself the start of a new frame.
          if (rise) begin
            stage_d = set_put(stage_q, IDX_0, w_q);
            idx_d   = IDX_1;
            state_d = ST_RUN;
          end else begin
            idx_d   = IDX_0;
            state_d = ST_HUNT;
          end
        end
      end
      default: begin
        idx_d   = IDX_0;
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q         <= 1'b0;
      f_p_q       <= 1'b0;
      w_q         <= '0;
      state_q     <= ST_HUNT;
      idx_q       <= IDX_0;
      stage_q     <= '0;
      snk_q       <= '0;
      snk_valid_q <= 1'b0;
      good_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      f_q         <= tx_frame;
      f_p_q       <= f_q;
      w_q         <= tx_data;
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      snk_q       <= snk_d;
      snk_valid_q <= snk_valid_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign src_ready   = src_ready_q;
  assign rx_frame    = rx_frame_q;
  assign rx_data     = rx_data_q;
  assign rx_underrun = rx_urun_q;
  assign snk_valid   = snk_valid_q;
  assign snk_i0      = snk_q.i0;
  assign snk_q0      = snk_q.q0;
  assign snk_i1      = snk_q.i1;
  assign snk_q1      = snk_q.q1;
  assign tx_locked   = locked_q;
  assign tx_err      = err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_ad9361_port_emu.sv
// Directed bench for ad9361_port_emu: table-driven RX framing and TX decoding
// vectors plus hand-written FIFO-full and mid-frame reset sequences.
module tb_ad9361_port_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [11:0] src_i0, src_q0, src_i1, src_q1;
  logic        rx_frame;
  logic [11:0] rx_data;
  logic        rx_underrun;
  logic        tx_frame;
  logic [11:0] tx_data;
  logic        snk_valid;
  logic [11:0] snk_i0, snk_q0, snk_i1, snk_q1;
  logic        tx_locked;
  logic        tx_err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [1:0] step_b;

  typedef struct packed {
    logic [11:0] i0, q0, i1, q1;
    logic [11:0] w0, w1, w2, w3;
  } rx_vec_t;

  typedef struct packed {
    logic        f;
    logic [11:0] w;
    logic        v;
    logic        e;
    logic        l;
    logic [15:0] cnt;
    logic [47:0] snk;
  } tx_vec_t;

  rx_vec_t rxv [3];
  tx_vec_t txv [$];

  always #5 clk = ~clk;

  ad9361_port_emu #(.LOCK_FRAMES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_i0(src_i0), .src_q0(src_q0), .src_i1(src_i1), .src_q1(src_q1),
    .rx_frame(rx_frame), .rx_data(rx_data), .rx_underrun(rx_underrun),
    .tx_frame(tx_frame), .tx_data(tx_data),
    .snk_valid(snk_valid),
    .snk_i0(snk_i0), .snk_q0(snk_q0), .snk_i1(snk_i1), .snk_q1(snk_q1),
    .tx_locked(tx_locked), .tx_err(tx_err), .err_count(err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) step_b = step_b + 2'd1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Sets are packed {q1, i1, q0, i0}.
  function automatic logic [11:0] word_b(input logic [47:0] s, input logic [1:0] st);
    logic [11:0] i0, q0, i1, q1, r;
    i0 = s[11:0]; q0 = s[23:12]; i1 = s[35:24]; q1 = s[47:36];
    case (st)
      2'd0:    r = {q0[11:6], i0[11:6]};
      2'd1:    r = {q0[5:0],  i0[5:0]};
      2'd2:    r = {q1[11:6], i1[11:6]};
      default: r = {q1[5:0],  i1[5:0]};
    endcase
    return r;
  endfunction

  function automatic logic [47:0] mk_set(input int k);
    logic [11:0] kk;
    kk = 12'(k);
    return {12'hA00 + kk, 12'h300 + kk, 12'h200 + kk, 12'h100 + kk};
  endfunction

  task automatic drive_src(input logic [47:0] s);
    src_i0 = s[11:0]; src_q0 = s[23:12]; src_i1 = s[35:24]; src_q1 = s[47:36];
  endtask

  task automatic add_tx(input logic f, input logic [11:0] w, input logic v, input logic e,
                        input logic l, input logic [15:0] cnt, input logic [47:0] snk);
    tx_vec_t t;
    t.f = f; t.w = w; t.v = v; t.e = e; t.l = l; t.cnt = cnt; t.snk = snk;
    txv.push_back(t);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_frame"},  rx_frame, 0);
    chk({tag, "_rx_data"},   rx_data, 0);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_underrun"},  rx_underrun, 0);
    chk({tag, "_snk_valid"}, snk_valid, 0);
    chk({tag, "_snk"},       {snk_q1, snk_i1, snk_q0, snk_i0}, 0);
    chk({tag, "_locked"},    tx_locked, 0);
    chk({tag, "_tx_err"},    tx_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [47:0] s1, s2, hold_m, cur;
    logic [47:0] mq [$];
    logic exp_ready, acc, urun_m, saw_low;
    int sent, popped;

    s1 = {12'hFFE, 12'h001, 12'h7FF, 12'h800};
    s2 = {12'hABC, 12'h789, 12'h456, 12'h123};
    rxv[0] = {12'hABC, 12'h123, 12'h456, 12'h789, 12'h12A, 12'h8FC, 12'h791, 12'h256};
    rxv[1] = {12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h03F, 12'h03F, 12'hFC0, 12'hFC0};
    rxv[2] = {12'h041, 12'h082, 12'h000, 12'h001, 12'h081, 12'h081, 12'h000, 12'h040};

    // TX rows: {frame, word, exp snk_valid, tx_err, tx_locked, err_count, held snk} two cycles later.
    add_tx(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0, 48'd0);
    add_tx(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0, 48'd0);
    for (int fr = 1; fr <= 5; fr++) begin
      add_tx(1'b1, 12'h7E0, 1'b0, 1'b0, fr >= 5, 16'd0, (fr > 1) ? s1 : 48'd0);
      add_tx(1'b1, 12'hFC0, 1'b0, 1'b0, fr >= 5, 16'd0, (fr > 1) ? s1 : 48'd0);
      add_tx(1'b0, 12'hFC0, 1'b0, 1'b0, fr >= 5, 16'd0, (fr > 1) ? s1 : 48'd0);
      add_tx(1'b0, 12'hF81, 1'b1, 1'b0, fr >= 4, 16'd0, s1);
    end
    add_tx(1'b1, 12'h7E0, 1'b0, 1'b0, 1'b1, 16'd0, s1);
    add_tx(1'b1, 12'hFC0, 1'b0, 1'b0, 1'b1, 16'd0, s1);
    add_tx(1'b1, 12'hFC0, 1'b0, 1'b1, 1'b0, 16'd1, s1);
    add_tx(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd1, s1);
    for (int fr = 1; fr <= 4; fr++) begin
      add_tx(1'b1, 12'h444, 1'b0, 1'b0, 1'b0, 16'd1, (fr > 1) ? s2 : s1);
      add_tx(1'b1, 12'h5A3, 1'b0, 1'b0, 1'b0, 16'd1, (fr > 1) ? s2 : s1);
      add_tx(1'b0, 12'hA9E, 1'b0, 1'b0, 1'b0, 16'd1, (fr > 1) ? s2 : s1);
      add_tx(1'b0, 12'hF09, 1'b1, 1'b0, fr == 4, 16'd1, s2);
    end

    rst_n = 1'b0; src_valid = 1'b0; drive_src(48'd0);
    tx_frame = 1'b0; tx_data = 12'h000; step_b = 2'd3;
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle framing: 1,1,0,0 with an underrun at every frame start.
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("idle_rx_frame", rx_frame, (step_b == 2'd0) || (step_b == 2'd1));
      chk("idle_rx_data", rx_data, 0);
      chk("idle_underrun", rx_underrun, step_b == 2'd0);
      chk("idle_src_ready", src_ready, 1);
    end

    for (int k = 0; k < 3; k++) begin
      while (step_b != 2'd2) tick();
      drive_src({rxv[k].q1, rxv[k].i1, rxv[k].q0, rxv[k].i0});
      src_valid = 1'b1;
      chk("rx_src_ready", src_ready, 1);
      tick();
      src_valid = 1'b0;
      tick();
      chk("rx_w0", rx_data, rxv[k].w0);
      chk("rx_f0", rx_frame, 1);
      chk("rx_urun0", rx_underrun, 0);
      tick();
      chk("rx_w1", rx_data, rxv[k].w1);
      chk("rx_f1", rx_frame, 1);
      chk("rx_urun1", rx_underrun, 0);
      tick();
      chk("rx_w2", rx_data, rxv[k].w2);
      chk("rx_f2", rx_frame, 0);
      tick();
      chk("rx_w3", rx_data, rxv[k].w3);
      chk("rx_f3", rx_frame, 0);
    end

    // FIFO_DEPTH+2 sets offered back-to-back against a small queue model.
    while (step_b != 2'd0) tick();
    hold_m = 48'd0; exp_ready = 1'b1; sent = 0; popped = 0; saw_low = 1'b0; cur = 48'd0;
    for (int c = 0; c < 64 && !(popped == 6 && step_b == 2'd3); c++) begin
      src_valid = (sent < 6);
      cur = mk_set(sent);
      drive_src(cur);
      chk("fifo_src_ready", src_ready, exp_ready);
      acc = src_valid && exp_ready;
      tick();
      urun_m = 1'b0;
      if (step_b == 2'd0) begin
        if (mq.size() > 0) begin
          hold_m = mq.pop_front();
          popped++;
        end else begin
          hold_m = 48'd0;
          urun_m = 1'b1;
        end
      end
      if (acc) begin
        mq.push_back(cur);
        sent++;
      end
      exp_ready = (mq.size() != 4);
      if (!src_ready) saw_low = 1'b1;
      chk("fifo_rx_data", rx_data, word_b(hold_m, step_b));
      chk("fifo_underrun", rx_underrun, urun_m);
    end
    src_valid = 1'b0;
    chk("fifo_saw_not_ready", saw_low, 1);

    // TX table: outputs for row r are compared two cycles after it is driven.
    for (int i = 0; i <= txv.size(); i++) begin
      if (i < txv.size()) begin
        tx_frame = txv[i].f;
        tx_data  = txv[i].w;
      end else begin
        tx_frame = 1'b1;
        tx_data  = 12'h444;
      end
      tick();
      if (i >= 1) begin
        chk("tx_snk_valid", snk_valid, txv[i-1].v);
        chk("tx_err", tx_err, txv[i-1].e);
        chk("tx_locked", tx_locked, txv[i-1].l);
        chk("tx_err_count", err_count, txv[i-1].cnt);
        chk("tx_snk", {snk_q1, snk_i1, snk_q0, snk_i0}, txv[i-1].snk);
      end
    end

    // Mid-frame reset with both sides busy and the FIFO holding data.
    tx_frame = 1'b1; tx_data = 12'h5A3; src_valid = 1'b1; drive_src(mk_set(7));
    tick();
    tx_frame = 1'b0; tx_data = 12'hA9E; drive_src(mk_set(8));
    tick();
    src_valid = 1'b0;
    chk("pre_reset_err_count", err_count, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tx_frame = 1'b0; tx_data = 12'h000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_b = 2'd3;
    tick();
    chk("post_reset_rx_frame", rx_frame, 1);
    chk("post_reset_rx_data", rx_data, 0);
    chk("post_reset_underrun", rx_underrun, 1);
    chk("post_reset_src_ready", src_ready, 1);
    for (int n = 0; n < 7; n++) begin
      tick();
      chk("post_reset_urun_seq", rx_underrun, step_b == 2'd0);
      chk("post_reset_rx_data_seq", rx_data, 0);
      chk("post_reset_tx_err", tx_err, 0);
      chk("post_reset_snk_valid", snk_valid, 0);
      chk("post_reset_err_count", err_count, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
